// File: rtl/bk_add_arbiter_if.sv
// bk_add_arbiter_if: requester, adder and response signals of bk_add_arbiter.
interface bk_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*12-1:0] req_a;
  logic [NREQ*12-1:0] req_b;
  logic [23:0]        add_in;
  logic [12:0]        add_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [12:0]        rsp_sum;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        ops_count;
  modport slave (
    input  req_valid, req_a, req_b, add_out, rsp_ready,
    output req_ready, add_in, rsp_valid, rsp_sum, rsp_id, ops_count
  );
  modport master (
    output req_valid, req_a, req_b, add_out, rsp_ready,
    input  req_ready, add_in, rsp_valid, rsp_sum, rsp_id, ops_count
  );
endinterface

// File: rtl/bk_add_arbiter.sv
// bk_add_arbiter: round-robin sharing of an external 12-bit adder with a one-entry response buffer.
module bk_add_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic clk,
  input logic rst_n,
  bk_add_arbiter_if.slave bus
);
  logic [IDW-1:0] ptr, win, idx;
  logic           found, grant;
  logic [11:0]    op_a [NREQ];
  logic [11:0]    op_b [NREQ];
  logic [11:0]    a, b;
  logic [23:0]    ilv;
  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign op_a[g] = bus.req_a[12*g +: 12];
    assign op_b[g] = bus.req_b[12*g +: 12];
  end
  // First valid requester at or after ptr, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  assign grant = rst_n && found && (!bus.rsp_valid || bus.rsp_ready);
  assign a = op_a[win];
  assign b = op_b[win];
  for (genvar g = 0; g < 12; g++) begin : g_ilv
    assign ilv[2*g]   = a[g];
    assign ilv[2*g+1] = b[g];
  end
  assign bus.add_in    = grant ? ilv : '0;
  assign bus.req_ready = grant ? (NREQ'(1) << win) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_id    <= '0;
      bus.ops_count <= '0;
      ptr           <= '0;
    end else if (grant) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_sum   <= bus.add_out;
      bus.rsp_id    <= win;
      bus.ops_count <= bus.ops_count + 16'd1;
      ptr           <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bk_add_arbiter.sv
// tb_bk_add_arbiter: directed and random checks of bk_add_arbiter against a behavioural model.
module tb_bk_add_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  bk_add_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  bk_add_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // Behavioural stand-in for the external Brent-Kung adder
  always_comb begin
    logic [11:0] xa, xb;
    xa = '0;
    xb = '0;
    for (int i = 0; i < 12; i++) begin
      xa[i] = bus.add_in[2*i];
      xb[i] = bus.add_in[2*i+1];
    end
    bus.add_out = 13'(xa) + 13'(xb);
  end
  int n_assert = 0;
  int n_fail = 0;
  logic        m_valid;
  logic [12:0] m_sum;
  int          m_id, m_ptr, last_win;
  logic [15:0] m_ops;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction
  function automatic logic [23:0] ilv(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 12; i++) begin
      r[2*i]   = a[i];
      r[2*i+1] = b[i];
    end
    return r;
  endfunction
  task automatic set_req(input int k, input logic v, input logic [11:0] a, input logic [11:0] b);
    bus.req_valid[k] = v;
    bus.req_a[12*k +: 12] = a;
    bus.req_b[12*k +: 12] = b;
  endtask
  task automatic all_req(input logic v);
    for (int k = 0; k < NREQ; k++) set_req(k, v, 12'(k), 12'd10);
  endtask
  task automatic check_regs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(m_valid));
    chk({tag, "_rsp_sum"},   32'(bus.rsp_sum),   32'(m_sum));
    chk({tag, "_rsp_id"},    32'(bus.rsp_id),    32'(m_id));
    chk({tag, "_ops_count"}, 32'(bus.ops_count), 32'(m_ops));
  endtask
  // Called at posedge+1 with inputs already applied; returns at the next posedge+1
  task automatic cycle();
    int w;
    logic [11:0] a, b;
    @(negedge clk);
    w = (!m_valid || bus.rsp_ready) ? pick(bus.req_valid, m_ptr) : -1;
    a = (w < 0) ? 12'd0 : bus.req_a[12*w +: 12];
    b = (w < 0) ? 12'd0 : bus.req_b[12*w +: 12];
    chk("req_ready", 32'(bus.req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
    chk("add_in", 32'(bus.add_in), (w < 0) ? 32'd0 : 32'(ilv(a, b)));
    @(posedge clk);
    last_win = w;
    if (w >= 0) begin
      m_valid = 1'b1;
      m_sum   = 13'(a) + 13'(b);
      m_id    = w;
      m_ptr   = (w + 1) % NREQ;
      m_ops   = m_ops + 16'd1;
    end else if (m_valid && bus.rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check_regs("cyc");
  endtask
  // Reset pulse lands between edges; release happens just after a posedge
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_sum = '0; m_id = 0; m_ptr = 0; m_ops = '0;
    check_regs("rst");
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_add_in", 32'(bus.add_in), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  initial begin
    logic [12:0] hold_sum;
    logic [IDW-1:0] hold_id;
    logic [15:0] hold_ops;
    int rr_order [6] = '{0, 1, 2, 3, 0, 1};
    bus.rsp_ready = 1'b0;
    all_req(1'b1);
    do_reset();
    all_req(1'b0);
    // Carry out of bit 11
    bus.rsp_ready = 1'b1;
    set_req(2, 1'b1, 12'hFFF, 12'h001);
    cycle();
    chk("carry_sum", 32'(bus.rsp_sum), 32'h1000);
    chk("carry_id", 32'(bus.rsp_id), 32'd2);
    chk("carry_ops", 32'(bus.ops_count), 32'd1);
    all_req(1'b1);
    cycle();
    chk("ptr_after_carry", 32'(last_win), 32'd3);
    all_req(1'b0);
    // Operand interleaving onto the adder bus
    set_req(0, 1'b1, 12'hA5A, 12'h000);
    #1;
    chk("ilv_a", 32'(bus.add_in), 32'h441144);
    cycle();
    chk("ilv_a_sum", 32'(bus.rsp_sum), 32'hA5A);
    set_req(0, 1'b1, 12'h000, 12'h5A5);
    #1;
    chk("ilv_b", 32'(bus.add_in), 32'h228822);
    cycle();
    chk("ilv_b_sum", 32'(bus.rsp_sum), 32'h5A5);
    all_req(1'b0);
    cycle();
    // Backpressure: buffer full, consumer stalled
    set_req(1, 1'b1, 12'h123, 12'h456);
    cycle();
    all_req(1'b1);
    bus.rsp_ready = 1'b0;
    hold_sum = bus.rsp_sum;
    hold_id  = bus.rsp_id;
    hold_ops = bus.ops_count;
    repeat (5) begin
      cycle();
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_sum", 32'(bus.rsp_sum), 32'(hold_sum));
      chk("bp_id", 32'(bus.rsp_id), 32'(hold_id));
      chk("bp_ops", 32'(bus.ops_count), 32'(hold_ops));
    end
    bus.rsp_ready = 1'b1;
    cycle();
    chk("drain_grant_win", 32'(last_win), 32'd2);
    chk("drain_grant_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b0;
    cycle();
    // Reset while holding a result, then round robin from requester 0
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_order", 32'(last_win), 32'(rr_order[i]));
      chk("rr_sum", 32'(bus.rsp_sum), 32'(10 + rr_order[i]));
    end
    // Counter wrap
    do_reset();
    bus.rsp_ready = 1'b1;
    repeat (65536) cycle();
    chk("wrap_ops", 32'(bus.ops_count), 32'd0);
    cycle();
    chk("wrap_next_win", 32'(last_win), 32'd0);
    // Random traffic; requesters hold their offer until it is taken
    for (int k = 0; k < NREQ; k++)
      set_req(k, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    repeat (500) begin
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      cycle();
      for (int k = 0; k < NREQ; k++)
        if (k == last_win || !bus.req_valid[k])
          set_req(k, 1'($urandom_range(0, 2) != 0), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
